lcd_write_arbiter: RTL and testbench
====================================

Name: lcd_write_arbiter

Overview:
- Shares the single character-buffer write port of the `lcd` driver between two requesters.
  - Requester 0: the settings-menu writer.
  - Requester 1: the live-measurement formatter.
- Grants whole frames, not single writes: one requester owns the port from first write to last write.
- Sequences the repaint pulse against the driver's busy flag, so no frame is corrupted or repainted mid-refresh.
- Sits between the UI menu/number logic and the `lcd` instance, and replaces the ad-hoc state-based mux.

Parameters:
- TIMEOUT, 255: idle cycles an owner may go without a write before its grant is revoked (range 1..65535).
- GUARD, 4: cycles to wait for busy to rise after a repaint pulse before treating the repaint as accepted.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  per-requester frame request (level); bit i = requester i
- wr  in  2  per-requester write strobe; valid only while the matching gnt bit is high
- last  in  2  qualifies wr: this write ends the frame
- dat_in  in  16  character codes; [7:0] = req0, [15:8] = req1
- addr_in  in  10  buffer addresses; [4:0] = req0, [9:5] = req1
- busy  in  1  `lcd` refresh in progress
- gnt  out  2  one-hot-or-zero ownership grant
- dat  out  8  to `lcd` dat
- addr  out  5  to `lcd` addr
- we  out  1  to `lcd` we
- repaint  out  1  one-cycle repaint request to `lcd`
- timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset values (asynchronous): state IDLE; gnt=0, dat=0, addr=0, we=0, repaint=0, timeout=0; watchdog=0; last_served=1, so requester 0 wins the first tie.
- States: IDLE, OWN, PAINT, SETTLE.
- IDLE:
  - Single req bit high: grant that requester.
  - Both high: grant the requester != last_served.
  - gnt is registered and rises the cycle after req is sampled, so req-to-gnt latency is 1.
  - Enter OWN; set last_served to the granted index; clear the watchdog.
- OWN (owner o):
  - Write path: wr[o] registers dat_in/addr_in slice o onto dat/addr and pulses we the next cycle (latency 1). we is never high for two cycles from one strobe.
  - Non-owner wr/last are ignored completely.
  - Frame end: wr[o]&last[o] performs the final write, drops gnt the next cycle, then enters PAINT.
  - Abort: req[o] low with no last drops gnt and returns to IDLE with no repaint. A write in the same cycle as the drop is still performed.
  - Watchdog: counts cycles without wr[o] and resets on each wr[o]. On reaching TIMEOUT: drop gnt, pulse timeout, go to IDLE, no repaint.
- PAINT: hold while busy=1. First cycle with busy=0: pulse repaint for exactly one cycle, enter SETTLE.
- SETTLE:
  - Wait until busy=1 or GUARD cycles elapse, whichever comes first.
  - Then wait for busy=0, then go to IDLE.
  - gnt stays 0 throughout PAINT and SETTLE; requests stay pending and are arbitrated in IDLE.
- Fairness: with both requesters continuously requesting, grants alternate 0,1,0,1.
- req deasserted before its grant is issued: nothing happens.
- Reset mid-frame: immediate return to the reset state; the partial frame is not repainted.
- Watchdog counter width is clog2(TIMEOUT+1); it saturates and never wraps.

Decomposition:
- Shared package ui_pkg holds:
  - state encoding (IDLE=0, OWN=1, PAINT=2, SETTLE=3);
  - LCD_DAT_W=8 and LCD_ADDR_W=5;
  - REQ_MENU=0 and REQ_MEAS=1.
- One natural sub-module: rr_pick2, a combinational 2-way round-robin chooser taking req and last_served and returning a one-hot grant. Everything else stays in lcd_write_arbiter.

Test Plan:
- Single frame: req=01; three writes (addr 0x01,0x02,0x03; dat 'G','a','i'; last on the third), busy=0 → gnt=01 one cycle after req; three we pulses each 1 cycle after its wr with matching dat/addr; gnt drops; exactly one repaint pulse; state returns to IDLE.
- Tie and fairness: req=11 held after reset; each frame is 2 writes, last on the second → grant order 01, 10, 01; non-owner wr pulses produce no we.
- Busy interlock: busy=1 held 20 cycles when a frame ends → repaint stays 0 for those 20 cycles and pulses on the first busy=0 cycle. Then busy rises 2 cycles later and stays high 10 cycles → no new gnt until busy falls.
- Watchdog: TIMEOUT=8; owner 1 writes once, then stays idle with req held → timeout pulses 8 cycles after the write; gnt=00; no repaint; requester 0 is served next if requesting.
- Abort and reset: owner 0 drops req after 2 writes without last → gnt=00 next cycle, no repaint. Separately, assert reset mid-frame asynchronously → all outputs 0 without waiting for a clk edge.

Source files
------------

// File: rtl/ui_pkg.sv
// ui_pkg: shared UI/LCD types and constants for the lcd write path.
package ui_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, PAINT = 2'd2, SETTLE = 2'd3} state_e;
    localparam int LCD_DAT_W  = 8;
    localparam int LCD_ADDR_W = 5;
    localparam int REQ_MENU   = 0;
    localparam int REQ_MEAS   = 1;
endpackage

// File: rtl/lcd_write_arbiter_rr_pick2.sv
// rr_pick2: combinational 2-way round-robin chooser; on a tie the requester
// that was not served last wins.
module rr_pick2
    import ui_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] gnt
);
    assign gnt[REQ_MENU] = req[REQ_MENU] & (~req[REQ_MEAS] | last_served);
    assign gnt[REQ_MEAS] = req[REQ_MEAS] & (~req[REQ_MENU] | ~last_served);
endmodule

// File: rtl/lcd_write_arbiter.sv
// lcd_write_arbiter: frame-granular sharing of the lcd character-buffer write
// port between the menu writer and the measurement formatter, with repaint sequencing.
module lcd_write_arbiter
    import ui_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int GUARD   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req,
    input  logic [1:0]            wr,
    input  logic [1:0]            last,
    input  logic [15:0]           dat_in,
    input  logic [9:0]            addr_in,
    input  logic                  busy,
    output logic [1:0]            gnt,
    output logic [LCD_DAT_W-1:0]  dat,
    output logic [LCD_ADDR_W-1:0] addr,
    output logic                  we,
    output logic                  repaint,
    output logic                  timeout
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam int GD_W = $clog2(GUARD + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    localparam logic [GD_W-1:0] GD_MAX = GD_W'(GUARD);

    state_e                  state_q, state_d;
    logic [1:0]              gnt_q, gnt_d, pick;
    logic                    last_served_q, last_served_d;
    logic [LCD_DAT_W-1:0]    dat_q, dat_d;
    logic [LCD_ADDR_W-1:0]   addr_q, addr_d;
    logic                    we_q, we_d, repaint_q, repaint_d, timeout_q, timeout_d;
    logic [WD_W-1:0]         wd_q, wd_d, wd_inc;
    logic [GD_W-1:0]         guard_q, guard_d;
    logic                    seen_q, seen_d;
    logic                    o, w_o, l_o;

    rr_pick2 u_pick (.req(req), .last_served(last_served_q), .gnt(pick));

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        last_served_d = last_served_q;
        dat_d         = dat_q;
        addr_d        = addr_q;
        we_d          = 1'b0;
        repaint_d     = 1'b0;
        timeout_d     = 1'b0;
        wd_d          = wd_q;
        guard_d       = guard_q;
        seen_d        = seen_q;
        o             = last_served_q;
        w_o           = wr[o];
        l_o           = last[o];
        wd_inc        = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
        unique case (state_q)
            IDLE: if (|req) begin
                gnt_d         = pick;
                last_served_d = pick[REQ_MEAS];
                wd_d          = '0;
                state_d       = OWN;
            end
            OWN: begin
                if (w_o) begin
                    dat_d  = o ? dat_in[15:8] : dat_in[7:0];
                    addr_d = o ? addr_in[9:5] : addr_in[4:0];
                    we_d   = 1'b1;
                end
                wd_d = w_o ? '0 : wd_inc;
                // Frame end beats abort, which beats the watchdog.
                if (w_o && l_o) begin
                    gnt_d   = '0;
                    state_d = PAINT;
                end else if (!req[o]) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (!w_o && wd_inc == WD_MAX) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            PAINT: if (!busy) begin
                repaint_d = 1'b1;
                guard_d   = '0;
                seen_d    = 1'b0;
                state_d   = SETTLE;
            end
            SETTLE: begin
                seen_d  = seen_q | busy;
                guard_d = (guard_q == GD_MAX) ? guard_q : guard_q + 1'b1;
                if (!busy && (seen_d || guard_q == GD_MAX)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            gnt_q         <= '0;
            last_served_q <= 1'b1;
            dat_q         <= '0;
            addr_q        <= '0;
            we_q          <= 1'b0;
            repaint_q     <= 1'b0;
            timeout_q     <= 1'b0;
            wd_q          <= '0;
            guard_q       <= '0;
            seen_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            last_served_q <= last_served_d;
            dat_q         <= dat_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            repaint_q     <= repaint_d;
            timeout_q     <= timeout_d;
            wd_q          <= wd_d;
            guard_q       <= guard_d;
            seen_q        <= seen_d;
        end
    end

    assign gnt     = gnt_q;
    assign dat     = dat_q;
    assign addr    = addr_q;
    assign we      = we_q;
    assign repaint = repaint_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb_lcd_write_arbiter: directed scenarios plus random traffic against a
// transaction-level reference of the arbiter.
module tb_lcd_write_arbiter;
    localparam int TO = 8;
    localparam int GD = 4;
    localparam int M_FREE = 0, M_HELD = 1, M_PAINT = 2, M_SETTLE = 3;

    logic        clk = 1'b0, reset = 1'b1;
    logic [1:0]  req = '0, wr = '0, last = '0;
    logic [15:0] dat_in = '0;
    logic [9:0]  addr_in = '0;
    logic        busy = 1'b0;
    logic [1:0]  gnt;
    logic [7:0]  dat;
    logic [4:0]  addr;
    logic        we, repaint, timeout;

    int n_vec = 0, n_err = 0;

    int         m_mode, m_last, m_idle, m_n;
    bit         m_seen, m_we, m_rep, m_to;
    logic [1:0] m_gnt;
    logic [7:0] m_dat;
    logic [4:0] m_addr;

    lcd_write_arbiter #(.TIMEOUT(TO), .GUARD(GD)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .last(last),
        .dat_in(dat_in), .addr_in(addr_in), .busy(busy), .gnt(gnt),
        .dat(dat), .addr(addr), .we(we), .repaint(repaint), .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_FREE; m_last = 1; m_idle = 0; m_n = 0; m_seen = 0;
        m_gnt = '0; m_dat = '0; m_addr = '0; m_we = 0; m_rep = 0; m_to = 0;
    endtask

    task automatic model_step();
        int o;
        m_we = 0; m_rep = 0; m_to = 0;
        case (m_mode)
            M_FREE: if (req != 2'b00) begin
                m_last = (req == 2'b11) ? 1 - m_last : (req[1] ? 1 : 0);
                m_gnt  = 2'(1 << m_last);
                m_mode = M_HELD;
                m_idle = 0;
            end
            M_HELD: begin
                o = m_last;
                if (wr[o]) begin
                    m_dat = dat_in[8*o +: 8]; m_addr = addr_in[5*o +: 5];
                    m_we = 1; m_idle = 0;
                end else m_idle++;
                if (wr[o] && last[o]) begin m_gnt = '0; m_mode = M_PAINT; end
                else if (!req[o]) begin m_gnt = '0; m_mode = M_FREE; end
                else if (m_idle >= TO) begin m_gnt = '0; m_to = 1; m_mode = M_FREE; end
            end
            M_PAINT: if (!busy) begin m_rep = 1; m_mode = M_SETTLE; m_n = 0; m_seen = 0; end
            default: begin
                if (busy) m_seen = 1;
                if (!busy && (m_seen || m_n >= GD)) m_mode = M_FREE;
                m_n++;
            end
        endcase
    endtask

    task automatic cmp_all();
        chk("gnt", gnt, m_gnt);
        chk("dat", dat, m_dat);
        chk("addr", addr, m_addr);
        chk("we", we, m_we);
        chk("repaint", repaint, m_rep);
        chk("timeout", timeout, m_to);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp_all();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        chk("rst_async", {gnt, dat, addr, we, repaint, timeout}, 0);
        cmp_all();
        req = '0; wr = '0; last = '0; busy = 1'b0;
        #2 reset = 1'b0;
    endtask

    task automatic wait_gnt(output logic [1:0] g);
        for (int k = 0; k < 60; k++) begin
            if (gnt != 2'b00) break;
            tick();
        end
        chk("gnt_wait", gnt != 2'b00, 1);
        g = gnt;
    endtask

    initial begin
        logic [7:0] msg [3];
        logic [1:0] ord [3];
        logic [1:0] g;
        int reps, k_to, dens;
        msg = '{8'h47, 8'h61, 8'h69};
        ord = '{2'b01, 2'b10, 2'b01};
        model_reset();
        #7;
        chk("rst_init", {gnt, dat, addr, we, repaint, timeout}, 0);
        cmp_all();
        #5 reset = 1'b0;

        // single frame from the menu writer
        req = 2'b01;
        tick();
        chk("gnt_lat", gnt, 2'b01);
        for (int i = 0; i < 3; i++) begin
            wr = 2'b01; last = {1'b0, i == 2};
            addr_in = {5'd0, 5'(i + 1)}; dat_in = {8'h00, msg[i]};
            tick();
            chk("we1", we, 1);
            chk("dat1", dat, msg[i]);
            chk("addr1", addr, i + 1);
        end
        wr = '0; last = '0; req = '0;
        chk("gnt_end", gnt, 0);
        reps = 0;
        for (int i = 0; i < 12; i++) begin tick(); reps += int'(repaint); end
        chk("rep_once", reps, 1);

        // tie and fairness, with non-owner strobes
        do_reset();
        req = 2'b11;
        for (int f = 0; f < 3; f++) begin
            wait_gnt(g);
            chk("order", g, ord[f]);
            wr = ~g; dat_in = 16'($urandom);
            tick();
            chk("nonown_we", we, 0);
            wr = 2'b11; last = 2'b00; dat_in = 16'($urandom); addr_in = 10'($urandom);
            tick();
            chk("own_we", we, 1);
            wr = 2'b11; last = 2'b11;
            tick();
            wr = '0; last = '0;
        end

        // busy interlock
        do_reset();
        req = 2'b01;
        wait_gnt(g);
        busy = 1'b1; wr = 2'b01; last = 2'b01;
        tick();
        wr = '0; last = '0; req = 2'b10;
        for (int i = 0; i < 20; i++) begin tick(); chk("rep_busy", repaint, 0); end
        busy = 1'b0;
        tick();
        chk("rep_rise", repaint, 1);
        tick();
        busy = 1'b1;
        for (int i = 0; i < 10; i++) begin tick(); chk("gnt_busy", gnt, 0); end
        busy = 1'b0;
        tick(); tick();
        chk("gnt_after", gnt, 2'b10);

        // watchdog on requester 1, then requester 0 served
        wr = 2'b10; dat_in = 16'h4100;
        tick();
        wr = '0; req = 2'b11; k_to = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (timeout) begin k_to = k; break; end
        end
        chk("wd_cycles", k_to, TO);
        chk("wd_gnt", gnt, 0);
        tick();
        chk("wd_next", gnt, 2'b01);

        // abort by owner 0 after two writes
        wr = 2'b01; tick(); tick();
        wr = '0; req = 2'b00;
        tick();
        chk("abort_gnt", gnt, 0);
        reps = 0;
        for (int i = 0; i < 10; i++) begin tick(); reps += int'(repaint); end
        chk("abort_rep", reps, 0);

        // asynchronous reset mid-frame
        req = 2'b01;
        wait_gnt(g);
        wr = 2'b01; dat_in = 16'h0055; addr_in = 10'h007;
        tick();
        chk("pre_rst_we", we, 1);
        wr = '0;
        do_reset();

        // random traffic
        dens = 4;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) dens = $urandom_range(1, 7);
            if ($urandom_range(0, 15) == 0) begin
                k_to = $urandom_range(0, 1);
                req[k_to] = ~req[k_to];
            end
            wr = {$urandom_range(0, 7) < dens, $urandom_range(0, 7) < dens};
            last = {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
            dat_in = 16'($urandom); addr_in = 10'($urandom);
            if ($urandom_range(0, 7) == 0) busy = ~busy;
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
